// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 8 lines x 16-byte blocks, 10-bit byte address.
// Hits return a word combinationally; a miss fetches the whole block, then installs it.
module instr_cache (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [9:0]   ADDRESS,
   input  logic         READ,
   output logic [31:0]  INSTRUCTION,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic [5:0]   MEM_ADDRESS,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MEM_READ = 2'd1;
   localparam logic [1:0] S_UPDATE   = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [7:0]   valid_q, valid_d;
   logic [2:0]   fill_tag_q, fill_tag_d;
   logic [2:0]   fill_index_q, fill_index_d;
   logic [127:0] fill_data_q, fill_data_d;

   logic [2:0]   tag_mem  [8];
   logic [127:0] data_mem [8];

   logic [2:0]   addr_tag;
   logic [2:0]   addr_index;
   logic [1:0]   addr_word;
   logic [1:0]   unused_addr_bits;
   logic [127:0] line_data;
   logic [31:0]  line_words [4];
   logic         hit;

   assign addr_tag         = ADDRESS[9:7];
   assign addr_index       = ADDRESS[6:4];
   assign addr_word        = ADDRESS[3:2];
   assign unused_addr_bits = ADDRESS[1:0];
   assign line_data        = data_mem[addr_index];
   assign hit              = valid_q[addr_index] && (tag_mem[addr_index] == addr_tag);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word
         assign line_words[gi] = line_data[32*gi +: 32];
      end
   endgenerate

   // Outputs are gated by RESET so they drop the instant reset rises.
   always_comb begin
      INSTRUCTION = 32'h0;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = 6'h00;
      if (!RESET) begin
         case (state_q)
            S_IDLE: begin
               if (READ) begin
                  if (hit) INSTRUCTION = line_words[addr_word];
                  else     BUSYWAIT    = 1'b1;
               end
            end
            S_MEM_READ: begin
               BUSYWAIT    = 1'b1;
               MEM_READ    = 1'b1;
               MEM_ADDRESS = {fill_tag_q, fill_index_q};
            end
            S_UPDATE: BUSYWAIT = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      fill_tag_d   = fill_tag_q;
      fill_index_d = fill_index_q;
      fill_data_d  = fill_data_q;
      case (state_q)
         S_IDLE: begin
            if (READ && !hit) begin
               fill_tag_d   = addr_tag;
               fill_index_d = addr_index;
               state_d      = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            if (!MEM_BUSYWAIT) begin
               fill_data_d = MEM_READDATA;
               state_d     = S_UPDATE;
            end
         end
         S_UPDATE: begin
            valid_d[fill_index_q] = 1'b1;
            state_d               = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         fill_tag_q   <= '0;
         fill_index_q <= '0;
         fill_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         fill_tag_q   <= fill_tag_d;
         fill_index_q <= fill_index_d;
         fill_data_q  <= fill_data_d;
      end
   end

   // Tag/data need no reset: reset forces IDLE, so an abandoned fill never writes.
   always_ff @(posedge CLK) begin
      if (state_q == S_UPDATE) begin
         tag_mem[fill_index_q]  <= fill_tag_q;
         data_mem[fill_index_q] <= fill_data_q;
      end
   end
endmodule

// File: tb/tb_instr_cache.sv
// Randomized scoreboard bench for instr_cache against an array-based cache/memory model.
// Stimulus pushes expected responses; a negedge monitor pops and checks them.
module tb_instr_cache;
   logic         CLK;
   logic         RESET;
   logic [9:0]   ADDRESS;
   logic         READ;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   instr_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ADDRESS      (ADDRESS),
      .READ         (READ),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   typedef struct packed {
      logic [9:0]  addr;
      logic [5:0]  blk;
      logic [31:0] instr;
      logic [31:0] stall;
      logic [31:0] mreads;
   } exp_t;

   logic [127:0] mem [64];
   bit           model_valid [8];
   logic [2:0]   model_tag   [8];
   exp_t         sb [$];

   int vectors;
   int miscompares;
   int cur_k;
   int mem_cnt;
   int mon_bw;
   int mon_mr;
   bit mon_en;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   task automatic abort_run(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
      finish_run();
   endtask

   // Instruction memory: MEM_BUSYWAIT high for cur_k cycles of each request, then data.
   initial begin
      mem_cnt = 0;
      forever begin
         @(negedge CLK);
         if (MEM_READ) begin
            if (mem_cnt < cur_k) begin
               MEM_BUSYWAIT = 1'b1;
               MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
               mem_cnt++;
            end else begin
               MEM_BUSYWAIT = 1'b0;
               MEM_READDATA = mem[MEM_ADDRESS];
            end
         end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b0;
         end
      end
   end

   // Monitor: counts stall cycles, checks the response when BUSYWAIT drops.
   initial begin
      exp_t e;
      mon_bw = 0;
      mon_mr = 0;
      forever begin
         @(negedge CLK);
         if (!mon_en) begin
            mon_bw = 0;
            mon_mr = 0;
         end else begin
            if (!MEM_READ) chk("mem_address_idle", {26'h0, MEM_ADDRESS}, 32'h0);
            if (!READ) begin
               chk("noread_busywait", {31'h0, BUSYWAIT}, 32'h0);
               chk("noread_instr", INSTRUCTION, 32'h0);
               chk("noread_mem_read", {31'h0, MEM_READ}, 32'h0);
            end else if (BUSYWAIT) begin
               mon_bw++;
               if (MEM_READ) begin
                  mon_mr++;
                  if (sb.size() > 0) chk("mem_address", {26'h0, MEM_ADDRESS}, {26'h0, sb[0].blk});
               end
            end else begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_response: instr %h with no request pending", INSTRUCTION);
               end else begin
                  e = sb.pop_front();
                  chk("instruction", INSTRUCTION, e.instr);
                  chk("stall_cycles", mon_bw, e.stall);
                  chk("mem_read_cycles", mon_mr, e.mreads);
                  chk("mem_read_on_serve", {31'h0, MEM_READ}, 32'h0);
                  $display("txn addr=%h instr=%h stall=%0d mem_read=%0d", e.addr, INSTRUCTION, mon_bw, mon_mr);
               end
               mon_bw = 0;
               mon_mr = 0;
            end
         end
      end
   end

   task automatic issue(input logic [9:0] a, input int k);
      exp_t         e;
      logic [127:0] b;
      logic [2:0]   idx;
      idx     = a[6:4];
      b       = mem[a[9:4]];
      e.addr  = a;
      e.blk   = a[9:4];
      e.instr = b[32*a[3:2] +: 32];
      if (model_valid[idx] && model_tag[idx] == a[9:7]) begin
         e.stall  = 0;
         e.mreads = 0;
      end else begin
         e.stall          = k + 3;
         e.mreads         = k + 1;
         model_valid[idx] = 1'b1;
         model_tag[idx]   = a[9:7];
      end
      cur_k   = k;
      READ    = 1'b1;
      ADDRESS = a;
      sb.push_back(e);
      for (int c = 0; ; c++) begin
         @(negedge CLK);
         if (!BUSYWAIT) break;
         if (c > 200) abort_run("busywait_release");
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_cycle();
      READ    = 1'b0;
      ADDRESS = 10'($urandom);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #2000000;
      abort_run("global_watchdog");
   end

   initial begin
      logic [9:0] a;
      vectors      = 0;
      miscompares  = 0;
      mon_en       = 1'b0;
      cur_k        = 0;
      READ         = 1'b1;
      ADDRESS      = 10'h3a4;
      RESET        = 1'b1;
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = '0;
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[0] = 128'h0000000D_0000000C_0000000B_0000000A;
      for (int i = 0; i < 8; i++) begin
         model_valid[i] = 1'b0;
         model_tag[i]   = 3'h0;
      end

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
      chk("reset_mem_read", {31'h0, MEM_READ}, 32'h0);
      chk("reset_mem_address", {26'h0, MEM_ADDRESS}, 32'h0);
      chk("reset_instr", INSTRUCTION, 32'h0);
      @(posedge CLK);
      #1;
      READ   = 1'b0;
      RESET  = 1'b0;
      mon_en = 1'b1;
      idle_cycle();

      issue(10'h000, 5);
      issue(10'h004, 0);
      issue(10'h008, 0);
      issue(10'h00c, 0);
      issue(10'h080, 2);
      issue(10'h000, 1);
      issue(10'h1f8, 0);
      issue(10'h1f0, 0);
      idle_cycle();

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 5) == 0) idle_cycle();
         else begin
            a      = 10'($urandom);
            a[9:8] = 2'b00;
            issue(a, $urandom_range(0, 4));
         end
      end
      idle_cycle();

      // Reset in the middle of a fill: outputs drop immediately and the line stays invalid.
      mon_en  = 1'b0;
      cur_k   = 10;
      READ    = 1'b1;
      ADDRESS = 10'h2c8;
      for (int c = 0; ; c++) begin
         @(negedge CLK);
         if (MEM_READ) break;
         if (c > 20) abort_run("mem_read_start");
      end
      @(negedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      chk("midfill_reset_mem_read", {31'h0, MEM_READ}, 32'h0);
      chk("midfill_reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
      chk("midfill_reset_instr", INSTRUCTION, 32'h0);
      chk("midfill_reset_mem_address", {26'h0, MEM_ADDRESS}, 32'h0);
      READ = 1'b0;
      #1;
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
      @(posedge CLK);
      #1;
      mon_en = 1'b1;
      issue(10'h2c8, 1);
      issue(10'h2cc, 0);
      for (int n = 0; n < 20; n++) begin
         a = 10'($urandom);
         issue(a, $urandom_range(0, 3));
      end
      idle_cycle();
      idle_cycle();
      mon_en = 1'b0;
      finish_run();
   end
endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameters: none; geometry fixed at 8 lines x 16-byte blocks, 10-bit byte address, 32-bit instructions.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 ADDRESS  in  10  CPU fetch byte address (PC[9:0]); [9:7] tag, [6:4] index, [3:2] word offset, [1:0] ignored.
REQ-005 READ  in  1  CPU fetch request.
REQ-006 INSTRUCTION  out  32  fetched instruction word.
REQ-007 BUSYWAIT  out  1  CPU stall; high while the request is not satisfied.
REQ-008 MEM_READ  out  1  block-read request to instruction memory.
REQ-009 MEM_ADDRESS  out  6  block address {tag,index} to instruction memory.
REQ-010 MEM_READDATA  in  128  returned block; word w in bits [32w+31:32w].
REQ-011 MEM_BUSYWAIT  in  1  memory busy; data valid in the cycle it is low while MEM_READ is high.

Function
REQ-012 Storage SHALL be 8 lines, each {valid, tag[2:0], data[127:0]}, direct-mapped by ADDRESS[6:4].
REQ-013 Hit SHALL be valid[index] AND tag[index]==ADDRESS[9:7], evaluated combinationally.
REQ-014 States SHALL be IDLE, MEM_READ and UPDATE.
REQ-015 IDLE: READ=1 and hit -> INSTRUCTION = data[index] word ADDRESS[3:2], BUSYWAIT=0, same cycle, no state change.
REQ-016 IDLE: READ=1 and miss -> BUSYWAIT=1 combinationally; {tag,index} latched and MEM_READ entered at next posedge.
REQ-017 MEM_READ: MEM_READ=1, MEM_ADDRESS=latched {tag,index}, BUSYWAIT=1; remain while MEM_BUSYWAIT=1; at posedge with MEM_BUSYWAIT=0 capture MEM_READDATA and go to UPDATE.
REQ-018 UPDATE: MEM_READ=0, BUSYWAIT=1; at next posedge write captured data, latched tag and valid=1 into latched index and return to IDLE.
REQ-019 Stall SHALL total K+3 cycles of BUSYWAIT, K = cycles MEM_BUSYWAIT is high during MEM_READ (K=0 allowed: one-cycle memory).
REQ-020 INSTRUCTION SHALL be 32'h0 whenever READ=0 or not a hit.
REQ-021 READ=0 in IDLE SHALL give BUSYWAIT=0, MEM_READ=0, no state change.
REQ-022 A started fill SHALL complete even if READ or ADDRESS change mid-fill; fill uses latched address only.
REQ-023 Miss to an occupied index SHALL overwrite that line (no write-back; instruction data read-only).
REQ-024 MEM_ADDRESS SHALL be 6'h00 outside MEM_READ.

Reset
REQ-025 RESET=1 SHALL immediately clear all valid bits, force IDLE, MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0, regardless of READ.
REQ-026 RESET during MEM_READ or UPDATE SHALL abandon the fill; no line written.
REQ-027 Data and tag arrays need not be cleared by reset.

Verification
REQ-028 Reset, READ=1, ADDRESS=10'h000, memory K=5 returning 128'h0000000D_0000000C_0000000B_0000000A -> BUSYWAIT high 8 cycles, MEM_READ high 6 cycles with MEM_ADDRESS=6'h00, then INSTRUCTION=32'h0000000A, BUSYWAIT=0.
REQ-029 Then ADDRESS=4, 8, 12 on consecutive cycles -> INSTRUCTION 32'h0000000B, 32'h0000000C, 32'h0000000D, BUSYWAIT=0, MEM_READ never asserted.
REQ-030 ADDRESS=10'h080 -> miss, MEM_ADDRESS=6'h08, line 0 replaced; returning to ADDRESS=10'h000 -> miss again.
REQ-031 Memory with MEM_BUSYWAIT held low (K=0) -> BUSYWAIT high exactly 3 cycles, MEM_READ high exactly 1 cycle.
REQ-032 RESET pulse mid-MEM_READ -> MEM_READ and BUSYWAIT drop without waiting for CLK; re-fetch of same address misses.
REQ-033 READ=0 with any ADDRESS -> BUSYWAIT=0, INSTRUCTION=32'h0, MEM_READ=0.
